// File: rtl/trend_pkg.sv
// trend_pkg: shared encodings, FSM states, trend weights/thresholds and LFSR polynomial
// Optional feature macro: TREND_MODEL_EN (consumers use trend_sum/TH_* only when it is defined)
package trend_pkg;
  typedef enum logic [1:0] {M_CONST = 2'b00, M_ALT = 2'b01, M_RAND = 2'b10, M_BURST = 2'b11} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [3:0] W3 = 4'd8, W2 = 4'd4, W1 = 4'd2, W0 = 4'd1;
  localparam logic [3:0] TH_HI = 4'd8, TH_LO = 4'd4;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  function automatic logic [3:0] trend_sum(input logic [3:0] w);
    return (w[3] ? W3 : 4'd0) + (w[2] ? W2 : 4'd0) + (w[1] ? W1 : 4'd0) + (w[0] ? W0 : 4'd0);
  endfunction
endpackage

// File: rtl/trend_lfsr.sv
// trend_lfsr: right-shifting Galois LFSR with synchronous load and advance
// Ports: clk, reset (async, active-high), load_i (reload seed), adv_i (one step), state_o (current state)
module trend_lfsr #(
  parameter int W = 16,
  parameter logic [W-1:0] MASK = W'(16'hB400),
  parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         adv_i,
  output logic [W-1:0] state_o
);
  // an all-zero state would lock up the register, so a zero seed becomes 1
  localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? W'(1) : SEED;
  logic [W-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load_i ? SEED_NZ : adv_i ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : '0)) : lfsr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr_q <= SEED_NZ;
    else lfsr_q <= lfsr_d;
  assign state_o = lfsr_q;
endmodule

// File: rtl/trend_stream_gen.sv
// trend_stream_gen: programmable serial bit-stream generator (const/alternate/random/burst)
// Ports: clk, reset (async, active-high); start/stop/step_en control; mode/density/run_len/length config
//        latched at start; bit_out/bit_valid stream; busy, done pulse, saturating count; exp_trend golden
//        trend decision, built only when TREND_MODEL_EN is defined, otherwise tied 0.
module trend_stream_gen
  import trend_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1),
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step_en,
  input  logic [1:0]       mode,
  input  logic [3:0]       density,
  input  logic [3:0]       run_len,
  input  logic [LEN_W-1:0] length,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count,
  output logic             exp_trend
);
  state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [3:0] dens_q, dens_d, rl_q, rl_d, pos_q, pos_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d;
  logic lvl_q, lvl_d, bit_q, bit_d, valid_q, valid_d, done_q, done_d;
  logic go, emit, last, gen_bit, wrap;
  logic [LFSR_W-1:0] lfsr;
  logic lfsr_unused;
  trend_lfsr #(.W(LFSR_W), .MASK(LFSR_W'(LFSR_MASK)), .SEED(SEED)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .load_i(go),
    .adv_i(emit && mode_q == M_RAND),
    .state_o(lfsr)
  );
  assign lfsr_unused = ^lfsr[LFSR_W-1:4];
  // alternate is latched as a burst of length 1, so one phase counter serves both
  always_comb begin
    go = state_q == S_IDLE && start;
    emit = state_q == S_RUN && step_en && !stop;
    last = emit && len_q != '0 && count_q == len_q - LEN_W'(1);
    wrap = pos_q == rl_q;
    gen_bit = mode_q == M_CONST ? |dens_q : mode_q == M_RAND ? lfsr[3:0] < dens_q : lvl_q;
    state_d = go ? S_RUN : (state_q == S_RUN && (stop || last)) ? S_DONE :
              state_q == S_DONE ? S_IDLE : state_q;
    mode_d = go ? mode_t'(mode) : mode_q;
    dens_d = go ? density : dens_q;
    rl_d = go ? (mode_t'(mode) == M_ALT ? 4'd0 : run_len) : rl_q;
    len_d = go ? length : len_q;
    pos_d = go ? 4'd0 : emit ? (wrap ? 4'd0 : pos_q + 4'd1) : pos_q;
    lvl_d = go ? 1'b1 : (emit && wrap) ? ~lvl_q : lvl_q;
    count_d = go ? '0 : (emit && count_q != '1) ? count_q + LEN_W'(1) : count_q;
    bit_d = emit ? gen_bit : bit_q;
    valid_d = emit;
    done_d = state_q == S_DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      mode_q <= M_CONST;
      dens_q <= '0;
      rl_q <= '0;
      len_q <= '0;
      pos_q <= '0;
      lvl_q <= 1'b0;
      count_q <= '0;
      bit_q <= 1'b0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      dens_q <= dens_d;
      rl_q <= rl_d;
      len_q <= len_d;
      pos_q <= pos_d;
      lvl_q <= lvl_d;
      count_q <= count_d;
      bit_q <= bit_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
`ifdef TREND_MODEL_EN
  // decision uses the window as it was before this bit shifts in
  logic [3:0] win_q, win_d, sum;
  logic trend_q, trend_d;
  always_comb begin
    sum = trend_sum(win_q);
    win_d = go ? 4'd0 : emit ? {win_q[2:0], gen_bit} : win_q;
    trend_d = go ? 1'b0 : !emit ? trend_q : sum >= TH_HI ? 1'b1 : sum < TH_LO ? 1'b0 : trend_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win_q <= '0;
      trend_q <= 1'b0;
    end else begin
      win_q <= win_d;
      trend_q <= trend_d;
    end
  assign exp_trend = trend_q;
`else
  assign exp_trend = 1'b0;
`endif
  assign bit_out = bit_q;
  assign bit_valid = valid_q;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign count = count_q;
endmodule
